// File: rtl/mult_booth_seq_if.sv
// Operand/result bundle for the sequential Booth multiplier.
// The master starts operations and the slave (the multiplier) returns results.
interface mult_booth_seq_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_seq.sv
// Signed 32x32 radix-2 Booth multiplier, one bit per clock, with an overflow flag.
// Optional MULT_EARLY_EXIT_EN: finishes as soon as the remaining multiplier bits need no Booth ops.
module mult_booth_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic              clock,
  input logic              reset,
  mult_booth_seq_if.slave  bus
);
  localparam int PW = 2*WIDTH + 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] count_reg;
  logic [WIDTH-1:0] m_reg;
  logic [PW-1:0]    p_reg;
  logic [WIDTH-1:0] result_reg;
  logic             exc_reg;
  logic             rdy_reg;
  logic             busy_reg;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   upper_next;
  logic [PW-1:0]    p_step;
  logic [PW-1:0]    p_final;
  logic [CNT_W-1:0] count_next;
  logic             finish;

  assign m_ext      = {m_reg[WIDTH-1], m_reg};
  assign count_next = count_reg + 1'b1;

  always_comb begin
    upper_next = p_reg[PW-1:WIDTH+1];
    case (p_reg[1:0])
      2'b01:   upper_next = p_reg[PW-1:WIDTH+1] + m_ext;
      2'b10:   upper_next = p_reg[PW-1:WIDTH+1] - m_ext;
      default: upper_next = p_reg[PW-1:WIDTH+1];
    endcase
  end

  assign p_step = {upper_next[WIDTH], upper_next, p_reg[WIDTH:1]};

`ifdef MULT_EARLY_EXIT_EN
  // After count_next iterations the unprocessed bits sit in p_step[WIDTH-count_next:0];
  // once they are uniform every remaining step is a pure shift, so collapse them.
  logic [WIDTH:0]   rem_mask;
  logic [WIDTH:0]   rem_bits;
  logic [CNT_W-1:0] shamt;

  assign rem_mask = {(WIDTH+1){1'b1}} >> count_next;
  assign rem_bits = p_step[WIDTH:0] & rem_mask;
  assign shamt    = LAST - count_next;
  assign finish   = (rem_bits == '0) || (rem_bits == rem_mask);
  assign p_final  = $signed(p_step) >>> shamt;
`else
  assign finish   = (count_next == LAST);
  assign p_final  = p_step;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      m_reg      <= '0;
      p_reg      <= '0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
      busy_reg   <= 1'b0;
    end else if (bus.ctrl_MULT) begin
      // A start from any state discards whatever was in flight.
      state_reg <= RUN;
      count_reg <= '0;
      m_reg     <= bus.data_operandA;
      p_reg     <= {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
      rdy_reg   <= 1'b0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        RUN: begin
          count_reg <= count_next;
          p_reg     <= p_step;
          if (finish) begin
            p_reg      <= p_final;
            result_reg <= p_final[WIDTH:1];
            // Representable only if the upper 33 bits replicate the result's sign bit.
            exc_reg    <= !((&p_final[PW-1:WIDTH]) || !(|p_final[PW-1:WIDTH]));
            rdy_reg    <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          rdy_reg   <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          rdy_reg   <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_result    = result_reg;
  assign bus.data_exception = exc_reg;
  assign bus.data_resultRDY = rdy_reg;
  assign bus.busy           = busy_reg;
endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench for mult_booth_seq: cycle-level behavioural model plus directed vectors.
// Honours MULT_EARLY_EXIT_EN when computing the expected completion time.
module tb_mult_booth_seq;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  mult_booth_seq_if #(.WIDTH(32)) bus ();

  mult_booth_seq dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Behavioural model: a pending product and the number of edges until it is due.
  logic        model_on = 1'b0;
  logic        m_pend   = 1'b0;
  int          m_left   = 0;
  longint      m_prod   = 0;
  logic [31:0] e_res    = '0;
  logic        e_exc    = 1'b0;
  logic        e_rdy    = 1'b0;
  logic        e_busy   = 1'b0;

  function automatic int lat_of(input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
    logic signed [31:0] s;
    logic signed [31:0] t;
    s = b;
    for (int k = 1; k <= 32; k++) begin
      t = s >>> (k - 1);
      if (t == 0 || t == -1) return k;
    end
    return 32;
`else
    return (b === 32'hx) ? 0 : 32;
`endif
  endfunction

  function automatic longint sprod(input logic [31:0] a, input logic [31:0] b);
    longint la;
    longint lb;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    return la * lb;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      model_on = 1'b1;
      m_pend = 1'b0;
      e_res = '0; e_exc = 1'b0; e_rdy = 1'b0; e_busy = 1'b0;
    end else if (bus.ctrl_MULT) begin
      m_prod = sprod(bus.data_operandA, bus.data_operandB);
      m_left = lat_of(bus.data_operandB);
      m_pend = 1'b1;
      e_rdy = 1'b0; e_busy = 1'b1;
    end else begin
      e_rdy = 1'b0;
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          e_res  = m_prod[31:0];
          e_exc  = (m_prod != longint'($signed(m_prod[31:0])));
          e_rdy  = 1'b1;
          e_busy = 1'b0;
          m_pend = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(posedge clock) begin
    #1;
    if (model_on) begin
      chk("cyc_rdy",    32'(bus.data_resultRDY), 32'(e_rdy));
      chk("cyc_busy",   32'(bus.busy),           32'(e_busy));
      chk("cyc_result", bus.data_result,         e_res);
      chk("cyc_exc",    32'(bus.data_exception), 32'(e_exc));
    end
  end

  // Called at posedge+1; the pulse is sampled on the next edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clock);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = ~a;
    bus.data_operandB = ~b;
  endtask

  task automatic wait_rdy(input string name, input logic [31:0] er, input logic ee,
                          output int cyc);
    logic found;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      @(posedge clock);
      #1;
      cyc++;
      if (bus.data_resultRDY) found = 1'b1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_rdy required=rdy within 40 cycles", name);
    end else begin
      chk({name, "_result"}, bus.data_result, er);
      chk({name, "_exc"}, 32'(bus.data_exception), 32'(ee));
    end
    $display("op %s result=%h exc=%0b cycles=%0d", name, bus.data_result,
             bus.data_exception, cyc);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ee);
    int cyc;
    start_op(a, b);
    wait_rdy(name, er, ee, cyc);
  endtask

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  vec_t vecs[6] = '{
    '{"neg7x6",     32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0},
    '{"ovf_pos",    32'h40000000, 32'd4,        32'h00000000, 1'b1},
    '{"min_x_m1",   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},
    '{"min_x_min",  32'h80000000, 32'h80000000, 32'h00000000, 1'b1},
    '{"zero",       32'h12345678, 32'h00000000, 32'h00000000, 1'b0},
    '{"max_x_m1",   32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0}
  };

  initial begin
    int cyc;
    logic [31:0] ra;
    logic [31:0] rb;
    longint p;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_result", bus.data_result, 32'h0);
    chk("reset_rdy", 32'(bus.data_resultRDY), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);

    // Basic latency and result.
    start_op(32'd3, 32'd4);
    wait_rdy("3x4", 32'd12, 1'b0, cyc);
`ifndef MULT_EARLY_EXIT_EN
    chk("3x4_latency", 32'(cyc), 32'd32);
`endif
    repeat (3) @(posedge clock);
    #1;

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].e);

    // Restart mid-operation: only the second operation completes.
    start_op(32'd5, 32'd5);
    repeat (9) @(posedge clock);
    #1;
    run_op("restart_2x9", 32'd2, 32'd9, 32'd18, 1'b0);

    // Reset in the middle of an operation aborts it.
    start_op(32'd11, 32'd13);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_result", bus.data_result, 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_exc", 32'(bus.data_exception), 32'h0);
    repeat (40) @(posedge clock);
    #1;
    chk("abort_no_rdy", 32'(bus.data_resultRDY), 32'h0);
    run_op("after_abort", 32'd11, 32'd13, 32'd143, 1'b0);

    // Start issued in the DONE cycle.
    start_op(32'd3, 32'd4);
    wait_rdy("pre_done", 32'd12, 1'b0, cyc);
    run_op("done_restart", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);

    // Random signed sweep.
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = (i < 8) ? $urandom : 32'($urandom_range(0, 255)) - 32'd128;
      p = sprod(ra, rb);
      run_op($sformatf("rnd%0d", i), ra, rb, p[31:0],
             p != longint'($signed(p[31:0])));
    end

    repeat (3) @(posedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end
endmodule
